mac_operand_sequencer: RTL and testbench



---
 rtl/mac_operand_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// Autonomous stimulus/check engine for a MAC datapath: streams a preloaded (a,b,c)
// table over valid/ready and checks every returned result against a*b+c.
module mac_operand_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned INFLIGHT   = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0]    cfg_a,
    input  logic [DATA_WIDTH-1:0]    cfg_b,
    input  logic [DATA_WIDTH-1:0]    cfg_c,
    input  logic [$clog2(DEPTH):0]   cfg_count,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [DATA_WIDTH-1:0]    op_a,
    output logic [DATA_WIDTH-1:0]    op_b,
    output logic [DATA_WIDTH-1:0]    op_c,
    input  logic                     res_valid,
    input  logic [OUT_WIDTH-1:0]     res_data,
    output logic [$clog2(DEPTH):0]   err_count,
    output logic [$clog2(DEPTH)-1:0] first_err_idx,
    output logic                     spurious,
    output logic                     timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
    localparam int unsigned OW = $clog2(INFLIGHT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] exp;
        logic [AW-1:0]        idx;
    } fifo_entry_t;

    state_t                  r_state, w_state_nxt;
    logic [3*DATA_WIDTH-1:0] r_table [DEPTH];
    fifo_entry_t             r_fifo  [INFLIGHT];
    logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
    logic [OW-1:0]           r_occ;
    logic [CW-1:0]           r_count, r_issue_idx, r_err_count;
    logic [AW-1:0]           r_first_err_idx;
    logic                    r_spurious, r_timeout;
    logic [TW-1:0]           r_tmo_cnt;

    logic                    w_busy, w_done, w_op_valid;
    logic                    w_full, w_empty, w_push, w_pop, w_mismatch;
    logic                    w_start_ok, w_tmo_run, w_tmo_fire;
    logic [DATA_WIDTH-1:0]   w_a, w_b, w_c;
    fifo_entry_t             w_head, w_new;

    always_ff @(posedge clk) begin
        if (cfg_we) r_table[cfg_addr] <= {cfg_a, cfg_b, cfg_c};
    end

    assign {w_a, w_b, w_c} = r_table[r_issue_idx[AW-1:0]];
    assign w_full     = (r_occ == OW'(INFLIGHT));
    assign w_empty    = (r_occ == '0);
    assign w_push     = w_op_valid && op_ready;
    assign w_pop      = res_valid && !w_empty;
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_mismatch = w_pop && (res_data != w_head.exp);
    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_new.exp  = OUT_WIDTH'(w_a) * OUT_WIDTH'(w_b) + OUT_WIDTH'(w_c);
    assign w_new.idx  = r_issue_idx[AW-1:0];

    // Watchdog only counts cycles with work outstanding and no result returning.
    assign w_tmo_run  = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_empty && !res_valid;
    assign w_tmo_fire = w_tmo_run && (r_tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_op_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = (cfg_count != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                w_busy     = 1'b1;
                w_op_valid = (r_issue_idx < r_count) && !w_full;
                if (w_tmo_fire)                  w_state_nxt = S_DONE;
                else if (r_issue_idx == r_count) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_tmo_fire || w_empty) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Expected-value FIFO storage; pointers and occupancy carry the reset.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_new;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_occ           <= '0;
            r_count         <= '0;
            r_issue_idx     <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_spurious      <= 1'b0;
            r_timeout       <= 1'b0;
            r_tmo_cnt       <= '0;
        end else begin
            if (w_start_ok) begin
                r_count         <= cfg_count;
                r_issue_idx     <= '0;
                r_err_count     <= '0;
                r_first_err_idx <= '0;
                r_spurious      <= 1'b0;
                r_timeout       <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + PW'(1);
                r_issue_idx <= r_issue_idx + CW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_mismatch) begin
                if (r_err_count == '0)          r_first_err_idx <= w_head.idx;
                if (r_err_count != {CW{1'b1}}) r_err_count     <= r_err_count + CW'(1);
            end
            if (res_valid && w_empty) r_spurious <= 1'b1;
            // Timeout abandons whatever is still in flight.
            if (w_tmo_fire) begin
                r_timeout <= 1'b1;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_occ     <= '0;
                r_tmo_cnt <= '0;
            end else if (w_tmo_run) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign busy          = w_busy;
    assign done          = w_done;
    assign op_valid      = w_op_valid;
    assign op_a          = w_op_valid ? w_a : '0;
    assign op_b          = w_op_valid ? w_b : '0;
    assign op_c          = w_op_valid ? w_c : '0;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;
    assign spurious      = r_spurious;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a small latency-configurable MAC model.
module tb_mac_operand_sequencer;

    localparam int INFL = 4;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_a, cfg_b, cfg_c;
    logic [4:0]  cfg_count;
    logic        start;
    logic        busy, done, op_valid, op_ready;
    logic [7:0]  op_a, op_b, op_c;
    logic        res_valid;
    logic [15:0] res_data;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic        spurious, timeout;

    int total = 0;
    int bad   = 0;

    logic [7:0]  tab_a [8];
    logic [7:0]  tab_b [8];
    logic [7:0]  tab_c [8];
    logic [15:0] exp_tab [8];

    typedef struct {
        logic [15:0] val;
        int          due;
    } pend_t;

    mac_operand_sequencer dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c),
        .cfg_count(cfg_count), .start(start),
        .busy(busy), .done(done),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .res_valid(res_valid), .res_data(res_data),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .spurious(spurious), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_addr = 4'(i);
            cfg_a    = tab_a[i];
            cfg_b    = tab_b[i];
            cfg_c    = tab_c[i];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Starts a run and plays the MAC: returns results `latency` cycles after each handshake.
    task automatic run_model(input int n_ops, input int latency, input int bad_idx,
                             input logic [15:0] ready_pat, output int hs_cnt,
                             output int max_out, output int stalls, output bit done_seen);
        pend_t       q[$];
        pend_t       p;
        int          res_cnt;
        int          out_pre;
        bit          prev_stall;
        logic [23:0] prev_ops;
        hs_cnt = 0; res_cnt = 0; max_out = 0; stalls = 0; done_seen = 1'b0;
        prev_stall = 1'b0; prev_ops = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                cfg_count = 5'(n_ops);
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_seen = 1'b1;
                total++;
                if (q.size() != 0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL done_early: pending=%0d busy=%b, want pending=0 busy=0", q.size(), busy);
                end
                break;
            end
            if (cyc == 1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_run: got %b want 1", busy);
                end
            end
            if (prev_stall) begin
                total++;
                if (op_valid !== 1'b1 || {op_a, op_b, op_c} !== prev_ops) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b ops=%h want v=1 ops=%h", op_valid, {op_a, op_b, op_c}, prev_ops);
                end
            end
            out_pre = hs_cnt - res_cnt;
            if (out_pre > max_out) max_out = out_pre;
            if (out_pre >= INFL) begin
                total++;
                if (op_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL full_stall: outstanding=%0d op_valid=%b want 0", out_pre, op_valid);
                end
            end
            res_valid = 1'b0;
            res_data  = '0;
            if (q.size() > 0 && q[0].due <= cyc) begin
                res_valid = 1'b1;
                res_data  = q[0].val;
                void'(q.pop_front());
                res_cnt++;
            end
            op_ready = ready_pat[cyc % 16];
            if (op_valid && op_ready && hs_cnt < 8) begin
                total++;
                if ({op_a, op_b, op_c} !== {tab_a[hs_cnt], tab_b[hs_cnt], tab_c[hs_cnt]}) begin
                    bad++;
                    $display("FAIL op_data[%0d]: got %h want %h", hs_cnt, {op_a, op_b, op_c},
                             {tab_a[hs_cnt], tab_b[hs_cnt], tab_c[hs_cnt]});
                end
                p.val = exp_tab[hs_cnt];
                if (hs_cnt == bad_idx) p.val = p.val ^ 16'd1;
                p.due = cyc + latency;
                q.push_back(p);
                hs_cnt++;
            end
            prev_stall = op_valid && !op_ready;
            if (prev_stall) stalls++;
            prev_ops = {op_a, op_b, op_c};
        end
        res_valid = 1'b0;
        op_ready  = 1'b0;
        start     = 1'b0;
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL run_bound: no done within 400 cycles, want done");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, op_valid, spurious, timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, op_valid, spurious, timeout});
        end
        total++;
        if ({op_a, op_b, op_c} !== 24'd0) begin
            bad++;
            $display("FAIL reset_ops: got %h want 0", {op_a, op_b, op_c});
        end
        total++;
        if (err_count !== 5'd0 || first_err_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset_err: got %0d/%0d want 0/0", err_count, first_err_idx);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int hs, mx, st;
        bit dn;
        run_model(4, 1, -1, 16'hFFFF, hs, mx, st, dn);
        total++;
        if (hs != 4 || dn != 1'b1) begin
            bad++;
            $display("FAIL basic_hs: got hs=%0d done=%b want 4/1", hs, dn);
        end
        total++;
        if (err_count !== 5'd0 || spurious !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL basic_err: got err=%0d sp=%b to=%b want 0/0/0", err_count, spurious, timeout);
        end
    endtask

    task automatic test_corrupt();
        int hs, mx, st;
        bit dn;
        run_model(4, 1, 2, 16'hFFFF, hs, mx, st, dn);
        total++;
        if (err_count !== 5'd1) begin
            bad++;
            $display("FAIL corrupt_count: got %0d want 1", err_count);
        end
        total++;
        if (first_err_idx !== 4'd2) begin
            bad++;
            $display("FAIL corrupt_idx: got %0d want 2", first_err_idx);
        end
    endtask

    task automatic test_stall();
        int hs, mx, st;
        bit dn;
        run_model(8, 6, -1, 16'b0110_0101_1011_1111, hs, mx, st, dn);
        total++;
        if (hs != 8 || err_count !== 5'd0) begin
            bad++;
            $display("FAIL stall_run: got hs=%0d err=%0d want 8/0", hs, err_count);
        end
        total++;
        if (mx != INFL) begin
            bad++;
            $display("FAIL stall_maxout: got %0d want %0d", mx, INFL);
        end
        total++;
        if (st == 0) begin
            bad++;
            $display("FAIL stall_seen: got %0d stalls want >0", st);
        end
    endtask

    task automatic test_zero_count();
        @(negedge clk);
        cfg_count = 5'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: got done=%b busy=%b want 1/0", done, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || err_count !== 5'd0 || spurious !== 1'b0) begin
            bad++;
            $display("FAIL zero_after: got done=%b busy=%b err=%0d sp=%b want 0/0/0/0", done, busy, err_count, spurious);
        end
        res_valid = 1'b1;
        res_data  = 16'h1234;
        @(negedge clk);
        res_valid = 1'b0;
        total++;
        if (spurious !== 1'b1 || err_count !== 5'd0) begin
            bad++;
            $display("FAIL spurious: got sp=%b err=%0d want 1/0", spurious, err_count);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        @(negedge clk);
        cfg_count = 5'd4;
        start     = 1'b1;
        op_ready  = 1'b1;
        res_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || n != 66) begin
            bad++;
            $display("FAIL timeout_cycle: got seen=%b n=%0d want 1/66", seen, n);
        end
        total++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_flag: got to=%b busy=%b want 1/0", timeout, busy);
        end
        op_ready = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_idle: got done=%b busy=%b to=%b want 0/0/1", done, busy, timeout);
        end
    endtask

    task automatic test_reset_mid_run();
        int hs, mx, st;
        bit dn;
        @(negedge clk);
        cfg_count = 5'd8;
        start     = 1'b1;
        op_ready  = 1'b1;
        res_valid = 1'b1;
        res_data  = 16'd0;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if (busy !== 1'b1 || spurious !== 1'b1 || err_count === 5'd0) begin
            bad++;
            $display("FAIL midrun_pre: got busy=%b sp=%b err=%0d want 1/1/>0", busy, spurious, err_count);
        end
        reset     = 1'b0;
        res_valid = 1'b0;
        op_ready  = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, op_valid, spurious, timeout} !== 5'b0 || {op_a, op_b, op_c} !== 24'd0) begin
            bad++;
            $display("FAIL midrun_reset: got flags=%b ops=%h want 0/0", {busy, done, op_valid, spurious, timeout}, {op_a, op_b, op_c});
        end
        total++;
        if (err_count !== 5'd0 || first_err_idx !== 4'd0) begin
            bad++;
            $display("FAIL midrun_err: got %0d/%0d want 0/0", err_count, first_err_idx);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrun_nodone: got done=%b busy=%b want 0/0", done, busy);
        end
        run_model(8, 1, -1, 16'hFFFF, hs, mx, st, dn);
        total++;
        if (hs != 8 || dn != 1'b1 || err_count !== 5'd0) begin
            bad++;
            $display("FAIL midrun_rerun: got hs=%0d done=%b err=%0d want 8/1/0", hs, dn, err_count);
        end
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_a = '0; cfg_b = '0; cfg_c = '0; cfg_count = '0;
        start = 1'b0; op_ready = 1'b0; res_valid = 1'b0; res_data = '0;

        tab_a[0] = 8'd3;   tab_b[0] = 8'd5;   tab_c[0] = 8'd7;   exp_tab[0] = 16'd22;
        tab_a[1] = 8'd255; tab_b[1] = 8'd255; tab_c[1] = 8'd255; exp_tab[1] = 16'd65280;
        tab_a[2] = 8'd12;  tab_b[2] = 8'd10;  tab_c[2] = 8'd4;   exp_tab[2] = 16'd124;
        tab_a[3] = 8'd16;  tab_b[3] = 8'd16;  tab_c[3] = 8'd0;   exp_tab[3] = 16'd256;
        tab_a[4] = 8'd2;   tab_b[4] = 8'd3;   tab_c[4] = 8'd4;   exp_tab[4] = 16'd10;
        tab_a[5] = 8'd100; tab_b[5] = 8'd200; tab_c[5] = 8'd50;  exp_tab[5] = 16'd20050;
        tab_a[6] = 8'd1;   tab_b[6] = 8'd1;   tab_c[6] = 8'd1;   exp_tab[6] = 16'd2;
        tab_a[7] = 8'd128; tab_b[7] = 8'd2;   tab_c[7] = 8'd0;   exp_tab[7] = 16'd256;

        test_reset();
        load_table();
        test_basic();
        test_corrupt();
        test_stall();
        test_zero_count();
        test_timeout();
        test_reset_mid_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
